// File: rtl/snoop_bus_sequencer_if.sv
// snoop_bus_sequencer_if: links the sequencer to instruction memory and the snooping CPU caches.
// Defining SNOOP_WRITEBACK_EN adds the dirty-snooper writeback handshake.
interface snoop_bus_sequencer_if #(
    parameter int N_CPU  = 3,
    parameter int TAG_W  = 3,
    parameter int INST_W = 10,
    parameter int PC_W   = 5
);
    logic [PC_W-1:0]   imem_addr;
    logic [INST_W-1:0] imem_data;
    logic [INST_W-1:0] inst;
    logic              hab_bus;
    logic [TAG_W+1:0]  bus_in;
    logic [N_CPU-1:0]  hab_cpu;
    logic [N_CPU-1:0]  controle;
    logic              shared;
    logic [N_CPU-1:0]  cpu_shared;
    logic              busy;
    logic              done;
`ifdef SNOOP_WRITEBACK_EN
    logic [N_CPU-1:0]  cpu_dirty;
    logic              mem_req;
    logic              mem_ack;
    modport master (
        output imem_addr, inst, hab_bus, bus_in, hab_cpu, controle, shared, busy, done, mem_req,
        input  imem_data, cpu_shared, cpu_dirty, mem_ack
    );
    modport slave (
        input  imem_addr, inst, hab_bus, bus_in, hab_cpu, controle, shared, busy, done, mem_req,
        output imem_data, cpu_shared, cpu_dirty, mem_ack
    );
`else
    modport master (
        output imem_addr, inst, hab_bus, bus_in, hab_cpu, controle, shared, busy, done,
        input  imem_data, cpu_shared
    );
    modport slave (
        input  imem_addr, inst, hab_bus, bus_in, hab_cpu, controle, shared, busy, done,
        output imem_data, cpu_shared
    );
`endif
endinterface

// File: rtl/snoop_bus_sequencer.sv
// snoop_bus_sequencer: fetches coherence instructions, strobes the bus, opens a snoop window and
// lets the issuing CPU complete. SNOOP_WRITEBACK_EN adds a WB stall for dirty snoopers.
module snoop_bus_sequencer #(
    parameter int N_CPU      = 3,
    parameter int ID_W       = 2,
    parameter int TAG_W      = 3,
    parameter int INST_W     = 10,
    parameter int PC_W       = 5,
    parameter int PROG_LEN   = 10,
    parameter int SNOOP_WAIT = 1
) (
    input logic clock,
    input logic clear,
    snoop_bus_sequencer_if.master sb
);
    typedef enum logic [2:0] {FETCH, DECODE, SNOOP, WAIT, COLLECT, EXEC, HALT, WB} state_t;
    // PROG_LEN == 2**PC_W truncates to 0, matching the wrapped pc after the last fetch
    localparam logic [PC_W-1:0] LAST_PC = PC_W'(PROG_LEN);
    state_t            state, next;
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
    logic [TAG_W+1:0]  msg;
    logic [N_CPU-1:0]  controle;
    logic              shared;
    logic              started;
    logic [3:0]        cnt;
    logic [ID_W-1:0]   id;
    logic [1:0]        op;
    logic              skip;
    logic              dirty;
    logic              ack;
    assign id   = inst[INST_W-1 -: ID_W];
    assign op   = inst[INST_W-ID_W-1 -: 2];
    assign skip = {1'b0, id} >= (ID_W+1)'(N_CPU) || op == 2'b11;
`ifdef SNOOP_WRITEBACK_EN
    logic [N_CPU-1:0] wb_mask;
    assign dirty = |(sb.cpu_dirty & ~controle);
    assign ack   = sb.mem_ack;
    always_ff @(posedge clock or posedge clear)
        if (clear)
            wb_mask <= '0;
        else if (state == COLLECT)
            wb_mask <= sb.cpu_dirty & ~controle;
`else
    assign dirty = 1'b0;
    assign ack   = 1'b0;
`endif
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state    <= FETCH;
            pc       <= '0;
            inst     <= '0;
            msg      <= '0;
            controle <= '0;
            shared   <= 1'b0;
            started  <= 1'b0;
            cnt      <= '0;
        end else begin
            state <= next;
            case (state)
                FETCH: begin
                    inst    <= sb.imem_data;
                    pc      <= pc + 1'b1;
                    started <= 1'b1;
                end
                DECODE: if (!skip) begin
                    controle <= N_CPU'(1) << id;
                    msg      <= {op, inst[TAG_W-1:0]};
                end
                SNOOP:   cnt <= 4'(SNOOP_WAIT);
                WAIT:    cnt <= cnt - 1'b1;
                COLLECT: shared <= |(sb.cpu_shared & ~controle);
                default: ;
            endcase
        end
    end
    always_comb begin
        next = state;
        case (state)
            FETCH:   next = DECODE;
            DECODE:  next = skip ? (pc == LAST_PC ? HALT : FETCH) : SNOOP;
            SNOOP:   next = WAIT;
            WAIT:    next = cnt == '0 ? COLLECT : WAIT;
            COLLECT: next = dirty ? WB : EXEC;
            WB:      next = ack ? EXEC : WB;
            EXEC:    next = pc == LAST_PC ? HALT : FETCH;
            default: next = HALT;
        endcase
    end
    // Strobes and enables are pure functions of state, so a reset clears them in the same instant
    always_comb begin
        sb.imem_addr = pc;
        sb.inst      = inst;
        sb.bus_in    = msg;
        sb.controle  = controle;
        sb.shared    = shared;
        sb.hab_bus   = state == SNOOP;
        sb.hab_cpu   = (state == WAIT || state == COLLECT) ? ~controle : state == EXEC ? controle : '0;
        sb.busy      = started && state != HALT;
        sb.done      = state == HALT;
`ifdef SNOOP_WRITEBACK_EN
        sb.mem_req   = state == WB;
        if (state == WB)
            sb.hab_cpu = wb_mask;
`endif
    end
endmodule
